// File: rtl/receiver_readout_arbiter.sv
// Round-robin arbiter handing one pending receiver word at a time to a valid/ack consumer, then re-arming that receiver's BMC decoder.
// out_valid two edges after a request is seen in IDLE; a stalled ack holds out_* and every other request indefinitely.
module receiver_readout_arbiter #(
  parameter int                  NUM_RECEIVERS = 4,
  parameter int                  DATA_WIDTH    = 17,
  parameter int                  TS_WIDTH      = 24,
  parameter logic [TS_WIDTH-1:0] MAX_AGE       = 24'd960000
) (
  input  logic                                clk_96MHz,
  input  logic                                reset,
  input  logic [TS_WIDTH-1:0]                 system_timestamp,
  input  logic [NUM_RECEIVERS-1:0]            data_availible,
  input  logic [NUM_RECEIVERS*DATA_WIDTH-1:0] decoded_data,
  input  logic [NUM_RECEIVERS*TS_WIDTH-1:0]   timestamp_last_data,
  input  logic                                out_ack,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [TS_WIDTH-1:0]                 out_timestamp,
  output logic [2:0]                          out_channel,
  output logic [NUM_RECEIVERS-1:0]            reset_bmc_decoder,
  output logic [7:0]                          drop_count
);

  localparam int SEL_W = $clog2(NUM_RECEIVERS);

  typedef enum logic [1:0] {IDLE, GRANT, PRESENT, RELEASE} state_t;

  state_t                   state, state_nxt;
  logic [SEL_W-1:0]         sel, sel_nxt;
  logic [SEL_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic                     holdoff;
  logic                     out_valid_nxt;
  logic [DATA_WIDTH-1:0]    out_data_nxt;
  logic [TS_WIDTH-1:0]      out_timestamp_nxt;
  logic [2:0]               out_channel_nxt;
  logic [NUM_RECEIVERS-1:0] reset_bmc_decoder_nxt;
  logic [7:0]               drop_count_nxt;

  logic [DATA_WIDTH-1:0]    word_arr [NUM_RECEIVERS];
  logic [TS_WIDTH-1:0]      ts_arr   [NUM_RECEIVERS];
  logic [TS_WIDTH-1:0]      age;
  logic [SEL_W-1:0]         pick;
  logic                     pick_vld;

  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_RECEIVERS) t = t - NUM_RECEIVERS;
    return SEL_W'(t);
  endfunction

  for (genvar g = 0; g < NUM_RECEIVERS; g++) begin : g_unpack
    assign word_arr[g] = decoded_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign ts_arr[g]   = timestamp_last_data[g*TS_WIDTH +: TS_WIDTH];
  end

  // Modulo subtraction keeps a word captured just before timestamp rollover young.
  assign age = system_timestamp - ts_arr[sel];

  // Scan from the highest offset down so the closest request to rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_RECEIVERS - 1; i >= 0; i--) begin
      if (data_availible[rr_index(rr_ptr, i)]) begin
        pick     = rr_index(rr_ptr, i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt             = state;
    sel_nxt               = sel;
    rr_ptr_nxt            = rr_ptr;
    out_valid_nxt         = out_valid;
    out_data_nxt          = out_data;
    out_timestamp_nxt     = out_timestamp;
    out_channel_nxt       = out_channel;
    reset_bmc_decoder_nxt = '0;
    drop_count_nxt        = drop_count;
    case (state)
      IDLE: begin
        if (!holdoff && pick_vld) begin
          sel_nxt   = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!data_availible[sel]) begin
          state_nxt = IDLE;
        end else if (age > MAX_AGE) begin
          if (drop_count != 8'hFF) drop_count_nxt = drop_count + 8'd1;
          reset_bmc_decoder_nxt = NUM_RECEIVERS'(1) << sel;
          state_nxt             = RELEASE;
        end else begin
          out_data_nxt      = word_arr[sel];
          out_timestamp_nxt = ts_arr[sel];
          out_channel_nxt   = 3'(sel);
          out_valid_nxt     = 1'b1;
          state_nxt         = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ack) begin
          out_valid_nxt         = 1'b0;
          reset_bmc_decoder_nxt = NUM_RECEIVERS'(1) << sel;
          state_nxt             = RELEASE;
        end
      end
      RELEASE: begin
        rr_ptr_nxt = rr_index(sel, 1);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (!reset) begin
      state             <= IDLE;
      sel               <= '0;
      rr_ptr            <= '0;
      holdoff           <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_timestamp     <= '0;
      out_channel       <= '0;
      reset_bmc_decoder <= '0;
      drop_count        <= '0;
    end else begin
      state             <= state_nxt;
      sel               <= sel_nxt;
      rr_ptr            <= rr_ptr_nxt;
      // Receiver needs the cycle after its re-arm pulse to drop its flag.
      holdoff           <= (state == RELEASE);
      out_valid         <= out_valid_nxt;
      out_data          <= out_data_nxt;
      out_timestamp     <= out_timestamp_nxt;
      out_channel       <= out_channel_nxt;
      reset_bmc_decoder <= reset_bmc_decoder_nxt;
      drop_count        <= drop_count_nxt;
    end
  end

endmodule

// File: doc/receiver_readout_arbiter.md
Name: receiver_readout_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer (pulse identification / UART framing path) between NUM_RECEIVERS single_receiver_manager instances.
- Picks one receiver with a pending decoded word, latches its data and timestamp, and presents them on a valid/ack interface.
- After the consumer accepts the word, or when the word is too old and is dropped, it pulses that receiver's BMC decoder reset to re-arm it.
- Sits between the per-face receiver managers and the consumer, on clk_96MHz.

Parameters:
NUM_RECEIVERS, 4, number of requesting receivers (2..8)
DATA_WIDTH, 17, decoded word width
TS_WIDTH, 24, timestamp width; matches system_timestamp
MAX_AGE, 24'd960000, maximum allowed age in clk_96MHz ticks (10 ms); older words are dropped

Ports:
clk_96MHz  input  1  system clock
reset  input  1  synchronous, active-low reset
system_timestamp  input  TS_WIDTH  free-running counter, wraps at all-ones
data_availible  input  NUM_RECEIVERS  per-receiver "word pending" level, held until decoder reset
decoded_data  input  NUM_RECEIVERS*DATA_WIDTH  packed words; receiver i is at [i*DATA_WIDTH +: DATA_WIDTH]
timestamp_last_data  input  NUM_RECEIVERS*TS_WIDTH  packed capture timestamps
out_ack  input  1  consumer accepts the presented word
out_valid  output  1  word presented
out_data  output  DATA_WIDTH  latched word
out_timestamp  output  TS_WIDTH  latched capture timestamp
out_channel  output  3  index of the source receiver
reset_bmc_decoder  output  NUM_RECEIVERS  one-cycle active-high re-arm pulse per receiver
drop_count  output  8  saturating count of stale words dropped

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE and rr_ptr to 0.
  - out_valid, out_data, out_timestamp, out_channel, reset_bmc_decoder and drop_count all go to 0.
  - Reset mid-transaction abandons the word without a decoder pulse. The receiver stays pending and is re-served after reset.
- FSM states: IDLE, GRANT, PRESENT, RELEASE.
- IDLE:
  - If data_availible is non-zero, choose the first set bit scanning from rr_ptr upward, modulo NUM_RECEIVERS. Register it as sel and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If data_availible[sel]==0 (request withdrawn), return to IDLE. No outputs change and there is no pulse.
  - Otherwise compute age = (system_timestamp - timestamp_last_data[sel]) mod 2^TS_WIDTH. Unsigned wrap-around subtraction is what makes a timestamp rollover non-stale.
  - If age > MAX_AGE: increment drop_count (saturate at 255) and go to RELEASE.
  - If age <= MAX_AGE: latch out_data, out_timestamp and out_channel=sel, set out_valid=1 and go to PRESENT.
- PRESENT:
  - Hold out_valid and all out_* stable until the first cycle with out_ack==1. On that cycle, clear out_valid on the next edge and go to RELEASE.
  - out_ack while out_valid==0 is ignored in every state.
  - No timeout applies in PRESENT; the consumer may stall indefinitely.
- RELEASE:
  - reset_bmc_decoder[sel]=1 for exactly this one cycle; all other bits stay 0.
  - Set rr_ptr = (sel+1) mod NUM_RECEIVERS and go to IDLE.
- IDLE ignores data_availible in the cycle immediately after RELEASE, because the receiver needs one cycle to drop its flag. Implement this with a one-cycle holdoff flag.
- Latency:
  - Request seen in IDLE at edge t gives out_valid=1 after edge t+2.
  - An ack at edge k gives the reset pulse in cycle k+1.
  - Minimum spacing between grants is 5 cycles.
- Fairness: a continuously requesting receiver is never served twice while another receiver is pending.
- Simultaneous requests are resolved purely by rr_ptr order.
- Out_data, out_timestamp and out_channel keep their last values when out_valid==0.

Test Plan:
- Single request: data_availible=4'b0100, word 17'h1ABCD, ts=24'h000100, system_timestamp=24'h000200, out_ack on the 1st valid cycle -> out_valid after 2 edges, out_data=17'h1ABCD, out_channel=2, reset_bmc_decoder=4'b0100 for 1 cycle, drop_count=0.
- All four requesting continuously, ack every presentation -> out_channel sequence 0,1,2,3,0,1, with each reset pulse matching its channel.
- Stale word: ts=24'h000000, system_timestamp=24'h0F0000 (age 983040 > 960000) -> out_valid never asserts, reset_bmc_decoder[ch] pulses once, drop_count increments to 1. Repeat 300 times -> drop_count holds at 255.
- Wrap-around: ts=24'hFFFF00, system_timestamp=24'h000100 (age 512) -> word presented, not dropped.
- Back-pressure: hold out_ack=0 for 50 cycles while other receivers request -> out_* stable, no reset pulses. Assert ack -> next channel is served in rr order.
- Withdrawn request and reset mid-operation:
  - data_availible[1] drops in GRANT -> return to IDLE, no pulse.
  - reset=0 during PRESENT -> out_valid=0, drop_count=0, rr_ptr=0, no reset_bmc_decoder pulse.
